// File: rtl/sigma_delta_dac_mc.sv
// sigma_delta_dac_mc
// Multi-channel sigma-delta DAC modulator (1st or 2nd order noise shaping).
// Unsigned offset-binary samples arrive over a valid/ready handshake into a
// single staging register and are moved to the active register on a tick.
// Every modulator steps on the divided tick and drives one PDM bit.
//
// Ports:
//   clk       clock
//   n_reset   asynchronous active-low reset
//   in_data   NCH*N sample word, channel c in bits [c*N +: N]
//   in_valid  sample word present
//   in_ready  staging register empty (registered)
//   mute      synchronous mute: zero input, clear modulator state
//   out       PDM bit per channel (registered)
//   tick      one-cycle pulse marking each modulator update edge (registered)
module sigma_delta_dac_mc #(
  parameter int unsigned N       = 16,
  parameter int unsigned NCH     = 2,
  parameter int unsigned ORDER   = 2,
  parameter int unsigned OSR_DIV = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [NCH*N-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mute,
  output logic [NCH-1:0]   out,
  output logic             tick
);

  localparam int unsigned CW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [NCH*N-1:0] staging;
  logic [NCH*N-1:0] active;

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sigma_delta_dac_mc: ORDER must be 1 or 2");
  end

  // Update-rate divider; tick is registered so it is high exactly while cnt==OSR_DIV-1
  assign cnt_next = (cnt == CW'(OSR_DIV - 1)) ? '0 : cnt + CW'(1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == CW'(OSR_DIV - 1));
    end
  end

  // Single-entry staging; in_ready doubles as the "staging empty" flag.
  // Accept and transfer are exclusive because transfer needs staging full.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      staging  <= '0;
      active   <= '0;
      in_ready <= 1'b1;
    end else if (in_valid && in_ready) begin
      staging  <= in_data;
      in_ready <= 1'b0;
    end else if (tick && !in_ready) begin
      active   <= staging;
      in_ready <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [N-1:0] x;
    logic         bit_q;

    assign x      = mute ? '0 : active[c*N +: N];
    assign out[c] = bit_q;

    if (ORDER == 1) begin : g_o1
      logic [N-1:0] acc;
      logic [N:0]   sum;

      // Carry of the phase accumulator is the output bit
      assign sum = {1'b0, acc} + {1'b0, x};

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          acc   <= '0;
          bit_q <= 1'b0;
        end else if (mute) begin
          acc   <= '0;
          bit_q <= 1'b0;
        end else if (tick) begin
          acc   <= sum[N-1:0];
          bit_q <= sum[N];
        end
      end
    end else begin : g_o2
      localparam int unsigned IW      = N + 4;
      localparam int unsigned SW      = N + 6;
      localparam int          SAT_MAX = (2 ** (N + 2)) - 1;
      localparam int          SAT_MIN = -(2 ** (N + 2));
      localparam int          FB_VAL  = 2 ** N;
      localparam logic signed [SW-1:0] S_MAX = SW'(SAT_MAX);
      localparam logic signed [SW-1:0] S_MIN = SW'(SAT_MIN);

      logic signed [IW-1:0] i1;
      logic signed [IW-1:0] i2;
      logic signed [IW-1:0] i1n;
      logic signed [IW-1:0] i2n;
      logic signed [SW-1:0] xs;
      logic signed [SW-1:0] fb;
      logic signed [SW-1:0] s1;
      logic signed [SW-1:0] s2;

      // Two cascaded integrators with saturating sums; the wider SW holds
      // the unclamped sums so the clamp compare sees the true value
      always_comb begin
        xs  = SW'(x);
        fb  = bit_q ? SW'(FB_VAL) : '0;
        s1  = SW'(i1) + xs - fb;
        i1n = IW'(s1);
        if (s1 > S_MAX) begin
          i1n = IW'(SAT_MAX);
        end else if (s1 < S_MIN) begin
          i1n = IW'(SAT_MIN);
        end
        s2  = SW'(i2) + SW'(i1n) - fb;
        i2n = IW'(s2);
        if (s2 > S_MAX) begin
          i2n = IW'(SAT_MAX);
        end else if (s2 < S_MIN) begin
          i2n = IW'(SAT_MIN);
        end
      end

      // Strictly positive threshold keeps a zero input silent from reset
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          i1    <= '0;
          i2    <= '0;
          bit_q <= 1'b0;
        end else if (mute) begin
          i1    <= '0;
          i2    <= '0;
          bit_q <= 1'b0;
        end else if (tick) begin
          i1    <= i1n;
          i2    <= i2n;
          bit_q <= !i2n[IW-1] && (i2n != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Bench for sigma_delta_dac_mc: one 1st-order instance (OSR_DIV=1) and one
// 2nd-order instance (OSR_DIV=4), N=8, two channels, checked every cycle
// against an integer reference model plus density and fresh-start checks.
module tb_sigma_delta_dac_mc;

  localparam int unsigned N    = 8;
  localparam int unsigned NCH  = 2;
  localparam int          OSR1 = 1;
  localparam int          OSR2 = 4;
  localparam int          FS   = 2 ** N;
  localparam int          SAT_HI = 4 * FS - 1;
  localparam int          SAT_LO = -4 * FS;

  logic             clk;
  logic             n_reset;
  logic [NCH*N-1:0] d1_data, d2_data;
  logic             d1_valid, d2_valid, d1_ready, d2_ready;
  logic             d1_mute, d2_mute, d1_tick, d2_tick;
  logic [NCH-1:0]   d1_out, d2_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sigma_delta_dac_mc #(.N(N), .NCH(NCH), .ORDER(1), .OSR_DIV(OSR1)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .in_data(d1_data), .in_valid(d1_valid),
    .in_ready(d1_ready), .mute(d1_mute), .out(d1_out), .tick(d1_tick)
  );

  sigma_delta_dac_mc #(.N(N), .NCH(NCH), .ORDER(2), .OSR_DIV(OSR2)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .in_data(d2_data), .in_valid(d2_valid),
    .in_ready(d2_ready), .mute(d2_mute), .out(d2_out), .tick(d2_tick)
  );

  int n_asserts = 0;
  int n_fail = 0;

  // Reference model state
  int cyc;
  bit m1_pend, m2_pend, m1_accepted, m2_accepted, m2_sat;
  int m1_stg[NCH], m1_act[NCH], m1_acc[NCH];
  int m2_stg[NCH], m2_act[NCH], m2_i1[NCH], m2_i2[NCH];
  bit m1_out[NCH], m2_out[NCH];
  logic [NCH*N-1:0] seen2[$];

  function automatic bit tick_exp(input int osr);
    return (cyc > 0) && ((cyc % osr) == osr - 1);
  endfunction

  function automatic int sat(input int v);
    if (v > SAT_HI) begin
      m2_sat = 1'b1;
      return SAT_HI;
    end
    if (v < SAT_LO) begin
      m2_sat = 1'b1;
      return SAT_LO;
    end
    return v;
  endfunction

  task automatic reset_model();
    cyc = 0;
    m1_pend = 0; m2_pend = 0; m1_accepted = 0; m2_accepted = 0;
    for (int c = 0; c < NCH; c++) begin
      m1_stg[c] = 0; m1_act[c] = 0; m1_acc[c] = 0; m1_out[c] = 0;
      m2_stg[c] = 0; m2_act[c] = 0; m2_i1[c] = 0; m2_i2[c] = 0; m2_out[c] = 0;
    end
  endtask

  // One clock edge of the reference, using the inputs present before the edge
  task automatic model_edge();
    bit t1, t2;
    int x, s, fb;
    m1_accepted = 0;
    m2_accepted = 0;
    if (!n_reset) return;
    t1 = tick_exp(OSR1);
    t2 = tick_exp(OSR2);
    for (int c = 0; c < NCH; c++) begin
      x = d1_mute ? 0 : m1_act[c];
      if (d1_mute) begin
        m1_acc[c] = 0; m1_out[c] = 0;
      end else if (t1) begin
        s = m1_acc[c] + x;
        m1_out[c] = (s >= FS);
        m1_acc[c] = s % FS;
      end
      x = d2_mute ? 0 : m2_act[c];
      if (d2_mute) begin
        m2_i1[c] = 0; m2_i2[c] = 0; m2_out[c] = 0;
      end else if (t2) begin
        fb = m2_out[c] ? FS : 0;
        m2_i1[c] = sat(m2_i1[c] + x - fb);
        m2_i2[c] = sat(m2_i2[c] + m2_i1[c] - fb);
        m2_out[c] = (m2_i2[c] > 0);
      end
    end
    m1_accepted = d1_valid && !m1_pend;
    if (m1_accepted) begin
      for (int c = 0; c < NCH; c++) m1_stg[c] = int'(d1_data[c*N +: N]);
      m1_pend = 1;
    end else if (t1 && m1_pend) begin
      for (int c = 0; c < NCH; c++) m1_act[c] = m1_stg[c];
      m1_pend = 0;
    end
    m2_accepted = d2_valid && !m2_pend;
    if (m2_accepted) begin
      for (int c = 0; c < NCH; c++) m2_stg[c] = int'(d2_data[c*N +: N]);
      m2_pend = 1;
    end else if (t2 && m2_pend) begin
      for (int c = 0; c < NCH; c++) m2_act[c] = m2_stg[c];
      m2_pend = 0;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] e1, e2;
    for (int c = 0; c < NCH; c++) begin
      e1[c] = m1_out[c];
      e2[c] = m2_out[c];
    end
    chk("d1_out", 32'(d1_out), 32'(e1));
    chk("d1_ready", 32'(d1_ready), 32'(!m1_pend));
    chk("d1_tick", 32'(d1_tick), 32'(tick_exp(OSR1)));
    chk("d2_out", 32'(d2_out), 32'(e2));
    chk("d2_ready", 32'(d2_ready), 32'(!m2_pend));
    chk("d2_tick", 32'(d2_tick), 32'(tick_exp(OSR2)));
  endtask

  task automatic step();
    if (d2_valid && d2_ready) seen2.push_back(d2_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [NCH*N-1:0] w1, input bit u1,
                      input logic [NCH*N-1:0] w2, input bit u2);
    d1_data = w1; d1_valid = u1;
    d2_data = w2; d2_valid = u2;
    for (int i = 0; i < 40 && (d1_valid || d2_valid); i++) begin
      step();
      if (m1_accepted) d1_valid = 1'b0;
      if (m2_accepted) d2_valid = 1'b0;
    end
    d1_valid = 1'b0;
    d2_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1[NCH];
    int c2[NCH];
    int ticks2, x0, n_acc, k_exp;
    logic [NCH*N-1:0] wa, wb;

    n_reset = 1'b0;
    d1_data = '0; d2_data = '0;
    d1_valid = 1'b0; d2_valid = 1'b0;
    d1_mute = 1'b0; d2_mute = 1'b0;
    reset_model();
    m2_sat = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all();
    n_reset = 1'b1;

    // DC run: order-1 exact densities, order-2 half-scale density and silence
    send({8'hFF, 8'h40}, 1'b1, {8'h00, 8'h80}, 1'b1);
    for (int c = 0; c < NCH; c++) begin
      c1[c] = 0;
      c2[c] = 0;
    end
    ticks2 = 0;
    for (int i = 0; i < 4300; i++) begin
      step();
      if (i >= 20 && i < 276) begin
        for (int c = 0; c < NCH; c++) c1[c] += int'(d1_out[c]);
      end
      if (tick_exp(OSR2)) begin
        ticks2++;
        if (ticks2 > 40 && ticks2 <= 40 + 1024) begin
          for (int c = 0; c < NCH; c++) c2[c] += int'(d2_out[c]);
        end
      end
    end
    chk("d1_ones_x40", 32'(c1[0]), 32'(64));
    chk("d1_ones_xFF", 32'(c1[1]), 32'(255));
    chk("d2_ones_x80_in_512pm2", 32'(c2[0] >= 510 && c2[0] <= 514), 32'(1));
    chk("d2_ones_x00", 32'(c2[1]), 32'(0));
    chk("d2_no_clamp_dc", 32'(m2_sat), 32'(0));

    // Random order-1 level, then back-to-back words into the divided instance
    x0 = int'($urandom_range(1, 254));
    send({8'h00, 8'(x0)}, 1'b1, '0, 1'b0);
    seen2.delete();
    wa = {8'($urandom_range(16, 240)), 8'($urandom_range(0, 255))};
    wb = {8'h01, 8'hFF};
    d2_data = wa;
    d2_valid = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      step();
      if (m2_accepted) begin
        n_acc++;
        d2_data = wb;
      end
    end
    d2_valid = 1'b0;
    chk("d2_accept_count", 32'(seen2.size()), 32'(2));
    if (seen2.size() >= 2) begin
      chk("d2_first_word", 32'(seen2[0]), 32'(wa));
      chk("d2_second_word", 32'(seen2[1]), 32'(wb));
    end
    for (int c = 0; c < NCH; c++) c1[c] = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i >= 10 && i < 266) begin
        for (int c = 0; c < NCH; c++) c1[c] += int'(d1_out[c]);
      end
    end
    chk("d1_ones_random", 32'(c1[0]), 32'(x0));
    chk("d1_ones_x00", 32'(c1[1]), 32'(0));

    // Mute for three cycles, then compare against a fresh start at x0
    d1_mute = 1'b1;
    d2_mute = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d1_muted_out", 32'(d1_out), 32'(0));
      chk("d2_muted_out", 32'(d2_out), 32'(0));
    end
    d1_mute = 1'b0;
    d2_mute = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      k_exp = (k * x0) / FS - ((k - 1) * x0) / FS;
      chk("d1_fresh_start", 32'(d1_out[0]), 32'(k_exp));
      chk("d1_fresh_start_ch1", 32'(d1_out[1]), 32'(0));
    end

    // Reset while a word is pending between ticks
    for (int i = 0; i < 8 && !tick_exp(OSR2); i++) step();
    step();
    d2_data = {8'hC0, 8'hA0};
    d2_valid = 1'b1;
    step();
    d2_valid = 1'b0;
    chk("d2_pending_before_reset", 32'(d2_ready), 32'(0));
    #1;
    n_reset = 1'b0;
    #1;
    reset_model();
    check_all();
    step();
    step();
    n_reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("d2_silent_after_reset", 32'(d2_out), 32'(0));
      chk("d1_silent_after_reset", 32'(d1_out), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
